// File: rtl/sdio_host_cmd_phy.sv
// sdio_host_cmd_phy: host-side SDIO CMD-line PHY.
// Serialises 48-bit command frames (start, tx, index, argument, CRC7, end)
// onto the CMD pad and captures the card's response with CRC, framing and
// timeout status.
// Optional feature macro: SDIO_HOST_RSPS_136_EN enables the 136-bit (R2)
// receive path; without it every response is 48 bits and o_rsps[127:40] is 0.
module sdio_host_cmd_phy #(
  parameter int NCR_TIMEOUT = 64,
  parameter int NCC_GAP     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_abort,
  output logic         o_ready,
  input  logic         i_cmd_stb,
  input  logic [5:0]   i_cmd,
  input  logic [31:0]  i_cmd_arg,
  input  logic         i_rsps_expected,
  input  logic         i_long_rsps,
  output logic         o_rsps_stb,
  output logic [127:0] o_rsps,
  output logic         o_rsps_crc_good,
  output logic         o_rsps_timeout,
  output logic         o_sdio_cmd_dir,
  output logic         o_sdio_cmd_out,
  input  logic         i_sdio_cmd_in
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_TURN,
    ST_WAIT_START,
    ST_RECV,
    ST_DONE,
    ST_GAP
  } state_t;

  // The receive shift register holds every bit after the start bit except the
  // end bit, which is taken straight from the pad on the final cycle.
`ifdef SDIO_HOST_RSPS_136_EN
  localparam int RX_W  = 127;
  localparam int RSP_W = 128;
`else
  localparam int RX_W  = 46;
  localparam int RSP_W = 40;
`endif

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [38:0]       tx_sr_q, tx_sr_d;
  logic [6:0]        crc_q, crc_d;
  logic [RX_W-1:0]   rx_sr_q, rx_sr_d;
  logic              tx_bit_q, tx_bit_d;
  logic              rsps_exp_q, rsps_exp_d;
  logic              ready_q, ready_d;
  logic              rsps_stb_q, rsps_stb_d;
  logic [RSP_W-1:0]  rsps_q, rsps_d;
  logic              crc_good_q, crc_good_d;
  logic              timeout_q, timeout_d;
  logic              dir_q, dir_d;
  logic              out_q, out_d;

  logic              is_long;
  logic [7:0]        rx_last;
  logic              rx_crc_cover;

`ifdef SDIO_HOST_RSPS_136_EN
  logic              long_q, long_d;
  assign is_long = long_q;
`else
  logic              unused_long;
  assign is_long     = 1'b0;
  assign unused_long = i_long_rsps;
`endif

  // Index of the end bit, counted from the first bit after the start bit.
  assign rx_last = is_long ? 8'd134 : 8'd46;

  // Short frames cover bits 47:8 (start bit adds nothing to a cleared CRC);
  // long frames cover bits 127:8 only, skipping the 8-bit header.
  assign rx_crc_cover = is_long ? ((cnt_q >= 8'd7) && (cnt_q <= 8'd126))
                                : (cnt_q <= 8'd38);

  // One CRC7 (x^7 + x^3 + 1) step for one serial bit, MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Next-state and next-output logic for the whole transaction sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_sr_d    = tx_sr_q;
    crc_d      = crc_q;
    rx_sr_d    = rx_sr_q;
    tx_bit_d   = tx_bit_q;
    rsps_exp_d = rsps_exp_q;
    ready_d    = ready_q;
    rsps_stb_d = 1'b0;
    rsps_d     = rsps_q;
    crc_good_d = crc_good_q;
    timeout_d  = timeout_q;
    dir_d      = dir_q;
    out_d      = out_q;
`ifdef SDIO_HOST_RSPS_136_EN
    long_d     = long_q;
`endif

    if (i_abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      dir_d   = 1'b0;
      out_d   = 1'b1;
      ready_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_cmd_stb) begin
            state_d    = ST_SEND;
            cnt_d      = '0;
            ready_d    = 1'b0;
            dir_d      = 1'b1;
            out_d      = 1'b0;
            tx_sr_d    = {1'b1, i_cmd, i_cmd_arg};
            crc_d      = '0;
            rsps_exp_d = i_rsps_expected;
            rsps_d     = '0;
            crc_good_d = 1'b0;
            timeout_d  = 1'b0;
`ifdef SDIO_HOST_RSPS_136_EN
            long_d     = i_long_rsps;
`endif
          end
        end

        ST_SEND: begin
          if (cnt_q == 8'd47) begin
            cnt_d = '0;
            out_d = 1'b1;
            if (rsps_exp_q) begin
              state_d = ST_TURN;
              dir_d   = 1'b1;
            end else begin
              state_d = ST_DONE;
              dir_d   = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q < 8'd39) begin
              out_d   = tx_sr_q[38];
              tx_sr_d = {tx_sr_q[37:0], 1'b0};
              crc_d   = crc7_step(crc_q, tx_sr_q[38]);
            end else if (cnt_q < 8'd46) begin
              out_d = crc_q[6];
              crc_d = {crc_q[5:0], 1'b0};
            end else begin
              out_d = 1'b1;
            end
          end
        end

        ST_TURN: begin
          state_d = ST_WAIT_START;
          cnt_d   = '0;
          dir_d   = 1'b0;
          out_d   = 1'b1;
        end

        ST_WAIT_START: begin
          if ((cnt_q >= 8'd2) && !i_sdio_cmd_in) begin
            state_d = ST_RECV;
            cnt_d   = '0;
            crc_d   = '0;
          end else if (cnt_q == 8'(NCR_TIMEOUT - 1)) begin
            state_d    = ST_GAP;
            cnt_d      = '0;
            rsps_stb_d = 1'b1;
            timeout_d  = 1'b1;
            crc_good_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        ST_RECV: begin
          if (cnt_q == rx_last) begin
            state_d    = ST_DONE;
            cnt_d      = '0;
            rsps_stb_d = 1'b1;
            timeout_d  = 1'b0;
            crc_good_d = (crc_q == rx_sr_q[6:0]) && !tx_bit_q && i_sdio_cmd_in;
`ifdef SDIO_HOST_RSPS_136_EN
            if (is_long) begin
              rsps_d = {rx_sr_q[126:0], i_sdio_cmd_in};
            end else begin
              rsps_d = {88'b0, 1'b0, rx_sr_q[45:7]};
            end
`else
            rsps_d = {1'b0, rx_sr_q[45:7]};
`endif
          end else begin
            cnt_d   = cnt_q + 8'd1;
            rx_sr_d = {rx_sr_q[RX_W-2:0], i_sdio_cmd_in};
            if (cnt_q == 8'd0) begin
              tx_bit_d = i_sdio_cmd_in;
            end
            if (rx_crc_cover) begin
              crc_d = crc7_step(crc_q, i_sdio_cmd_in);
            end
          end
        end

        ST_DONE: begin
          state_d = ST_GAP;
          cnt_d   = '0;
          dir_d   = 1'b0;
          out_d   = 1'b1;
        end

        ST_GAP: begin
          if (cnt_q == 8'(NCC_GAP - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
          dir_d   = 1'b0;
          out_d   = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs; reset releases the pad immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_sr_q    <= '0;
      crc_q      <= '0;
      rx_sr_q    <= '0;
      tx_bit_q   <= 1'b0;
      rsps_exp_q <= 1'b0;
      ready_q    <= 1'b1;
      rsps_stb_q <= 1'b0;
      rsps_q     <= '0;
      crc_good_q <= 1'b0;
      timeout_q  <= 1'b0;
      dir_q      <= 1'b0;
      out_q      <= 1'b1;
`ifdef SDIO_HOST_RSPS_136_EN
      long_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_sr_q    <= tx_sr_d;
      crc_q      <= crc_d;
      rx_sr_q    <= rx_sr_d;
      tx_bit_q   <= tx_bit_d;
      rsps_exp_q <= rsps_exp_d;
      ready_q    <= ready_d;
      rsps_stb_q <= rsps_stb_d;
      rsps_q     <= rsps_d;
      crc_good_q <= crc_good_d;
      timeout_q  <= timeout_d;
      dir_q      <= dir_d;
      out_q      <= out_d;
`ifdef SDIO_HOST_RSPS_136_EN
      long_q     <= long_d;
`endif
    end
  end

  assign o_ready         = ready_q;
  assign o_rsps_stb      = rsps_stb_q;
  assign o_rsps_crc_good = crc_good_q;
  assign o_rsps_timeout  = timeout_q;
  assign o_sdio_cmd_dir  = dir_q;
  assign o_sdio_cmd_out  = out_q;
`ifdef SDIO_HOST_RSPS_136_EN
  assign o_rsps = rsps_q;
`else
  assign o_rsps = {88'b0, rsps_q};
`endif

endmodule

// File: tb/tb_sdio_host_cmd_phy.sv
// tb_sdio_host_cmd_phy: randomized, self-checking bench for sdio_host_cmd_phy.
// A frame-level model builds command and response frames with CRC7 computed by
// polynomial division and predicts response timing and status.
module tb_sdio_host_cmd_phy;

  localparam int NCR = 64;
  localparam int NCC = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_abort = 1'b0;
  logic         i_cmd_stb = 1'b0;
  logic [5:0]   i_cmd = '0;
  logic [31:0]  i_cmd_arg = '0;
  logic         i_rsps_expected = 1'b0;
  logic         i_long_rsps = 1'b0;
  logic         i_sdio_cmd_in = 1'b1;
  logic         o_ready;
  logic         o_rsps_stb;
  logic [127:0] o_rsps;
  logic         o_rsps_crc_good;
  logic         o_rsps_timeout;
  logic         o_sdio_cmd_dir;
  logic         o_sdio_cmd_out;

  int checks = 0;
  int failures = 0;

  sdio_host_cmd_phy #(.NCR_TIMEOUT(NCR), .NCC_GAP(NCC)) dut (
    .clk(clk), .rst_n(rst_n), .i_abort(i_abort), .o_ready(o_ready),
    .i_cmd_stb(i_cmd_stb), .i_cmd(i_cmd), .i_cmd_arg(i_cmd_arg),
    .i_rsps_expected(i_rsps_expected), .i_long_rsps(i_long_rsps),
    .o_rsps_stb(o_rsps_stb), .o_rsps(o_rsps), .o_rsps_crc_good(o_rsps_crc_good),
    .o_rsps_timeout(o_rsps_timeout), .o_sdio_cmd_dir(o_sdio_cmd_dir),
    .o_sdio_cmd_out(o_sdio_cmd_out), .i_sdio_cmd_in(i_sdio_cmd_in)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crcModel(input logic [119:0] data, input int nbits);
    logic [127:0] v;
    logic [127:0] g;
    v = {1'b0, data, 7'b0};
    g = 128'h89;
    for (int i = nbits + 6; i >= 7; i--) begin
      if (v[i]) v = v ^ (g << (i - 7));
    end
    return v[6:0];
  endfunction

  function automatic logic [47:0] cmdFrame(input logic [5:0] cmd, input logic [31:0] arg);
    logic [39:0] head;
    head = {2'b01, cmd, arg};
    return {head, crcModel({80'b0, head}, 40), 1'b1};
  endfunction

  // mode 0 good, 1 bad CRC, 2 tx bit set, 3 end bit cleared
  function automatic logic [47:0] shortResp(input logic [37:0] content, input int mode);
    logic [39:0] head;
    logic [6:0]  crc;
    head = {2'b00, content};
    if (mode == 2) head[38] = 1'b1;
    crc = crcModel({80'b0, head}, 40);
    if (mode == 1) crc = crc ^ 7'h04;
    return {head, crc, (mode == 3) ? 1'b0 : 1'b1};
  endfunction

  function automatic logic [135:0] longResp(input logic [119:0] content, input int mode);
    logic [7:0] hdr;
    logic [6:0] crc;
    hdr = 8'b0011_1111;
    if (mode == 2) hdr[6] = 1'b1;
    crc = crcModel(content, 120);
    if (mode == 1) crc = crc ^ 7'h20;
    return {hdr, content, crc, (mode == 3) ? 1'b0 : 1'b1};
  endfunction

  // Runs one full transaction, playing the card, and checks frame, timing and status.
  task automatic applyStimulus(input logic [5:0] cmd, input logic [31:0] arg,
                               input logic rsp_exp, input logic long_req,
                               input logic responds, input int delay, input logic [1:0] glitch,
                               input logic [135:0] resp_frame, input logic [47:0] exp_cmd_frame,
                               input logic [127:0] exp_rsps, input logic exp_crc_good,
                               input logic stray_stb);
    int n_bits, stb_exp, ready_exp, stb_count, stb_cycle, ready_cycle, j;
    logic is_long, ready0, dir_send_ok, dir_wait_ok, turn_ok, no_queue_ok;
    logic crc_seen, to_seen;
    logic [47:0] pad_bits;
    logic [127:0] rsps_seen;
`ifdef SDIO_HOST_RSPS_136_EN
    is_long = rsp_exp && long_req;
`else
    is_long = 1'b0;
`endif
    n_bits = is_long ? 136 : 48;
    if (!rsp_exp) begin
      stb_exp = -1;
      ready_exp = 48 + 1 + NCC;
    end else if (responds) begin
      stb_exp = 49 + delay + n_bits;
      ready_exp = stb_exp + 1 + NCC;
    end else begin
      stb_exp = 49 + NCR;
      ready_exp = stb_exp + NCC;
    end
    stb_count = 0; stb_cycle = -1; ready_cycle = -1;
    ready0 = 1'b1; dir_send_ok = 1'b1; dir_wait_ok = 1'b1; turn_ok = 1'b0;
    crc_seen = 1'b0; to_seen = 1'b0; pad_bits = '0; rsps_seen = '0;

    @(negedge clk);
    checkOutput("readyBeforeCmd", 128'(o_ready), 128'(1));
    i_cmd = cmd; i_cmd_arg = arg; i_rsps_expected = rsp_exp; i_long_rsps = long_req;
    i_cmd_stb = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      i_cmd_stb = stray_stb && (c == 10);
      if (c < 48) begin
        pad_bits = {pad_bits[46:0], o_sdio_cmd_out};
        if (!o_sdio_cmd_dir) dir_send_ok = 1'b0;
      end
      if (c == 0) ready0 = o_ready;
      if (c == 48 && rsp_exp) turn_ok = o_sdio_cmd_dir && o_sdio_cmd_out;
      if (rsp_exp && c >= 49 && c <= stb_exp && o_sdio_cmd_dir) dir_wait_ok = 1'b0;
      if (o_rsps_stb) begin
        stb_count++; stb_cycle = c;
        rsps_seen = o_rsps; crc_seen = o_rsps_crc_good; to_seen = o_rsps_timeout;
      end
      if (c > 0 && o_ready) begin
        ready_cycle = c;
        break;
      end
      j = c - 49;
      if (rsp_exp && j >= 0 && j < 2) i_sdio_cmd_in = glitch[j];
      else if (rsp_exp && responds && j >= delay && j < delay + n_bits)
        i_sdio_cmd_in = resp_frame[n_bits - 1 - (j - delay)];
      else i_sdio_cmd_in = 1'b1;
    end
    i_sdio_cmd_in = 1'b1;
    i_cmd_stb = 1'b0;

    checkOutput("cmdFrame", 128'(pad_bits), 128'(exp_cmd_frame));
    checkOutput("dirSend", 128'(dir_send_ok), 128'(1));
    checkOutput("readyDrop", 128'(ready0), 128'(0));
    if (rsp_exp) begin
      checkOutput("turn", 128'(turn_ok), 128'(1));
      checkOutput("dirWait", 128'(dir_wait_ok), 128'(1));
      checkOutput("stbCycle", 128'(stb_cycle), 128'(stb_exp));
      checkOutput("rsps", rsps_seen, exp_rsps);
      checkOutput("crcGood", 128'(crc_seen), 128'(exp_crc_good));
      checkOutput("timeout", 128'(to_seen), 128'(!responds));
    end
    checkOutput("stbCount", 128'(stb_count), 128'(rsp_exp ? 1 : 0));
    checkOutput("readyCycle", 128'(ready_cycle), 128'(ready_exp));
    checkOutput("holdRsps", o_rsps, rsp_exp ? exp_rsps : 128'(0));
    checkOutput("holdCrc", 128'(o_rsps_crc_good), 128'(rsp_exp && exp_crc_good));
    checkOutput("holdTimeout", 128'(o_rsps_timeout), 128'(rsp_exp && !responds));
    no_queue_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_sdio_cmd_dir || !o_ready) no_queue_ok = 1'b0;
    end
    checkOutput("noQueue", 128'(no_queue_ok), 128'(1));
  endtask

  // Builds a random transaction and its expected results from the frame model.
  task automatic randomTransaction();
    logic [5:0] cmd;
    logic [31:0] arg;
    logic rsp_exp, long_req, responds, is_long, stray;
    logic [1:0] glitch;
    logic [127:0] rnd, exp_rsps;
    logic [135:0] frame;
    logic [47:0] sf;
    int delay, mode;
    cmd = 6'($urandom); arg = $urandom;
    rsp_exp = ($urandom_range(0, 3) != 0);
    long_req = 1'($urandom);
    responds = ($urandom_range(0, 4) != 0);
    delay = $urandom_range(2, 63);
    glitch = 2'($urandom);
    mode = $urandom_range(0, 3);
    stray = 1'($urandom);
    rnd = {$urandom, $urandom, $urandom, $urandom};
`ifdef SDIO_HOST_RSPS_136_EN
    is_long = rsp_exp && long_req;
`else
    is_long = 1'b0;
`endif
    if (is_long) begin
      frame = longResp(rnd[119:0], mode);
      exp_rsps = frame[127:0];
    end else begin
      sf = shortResp(rnd[37:0], mode);
      frame = {88'b0, sf};
      exp_rsps = {88'b0, sf[47:8]};
    end
    if (!rsp_exp || !responds) exp_rsps = '0;
    applyStimulus(cmd, arg, rsp_exp, long_req, responds, delay, glitch, frame,
                  cmdFrame(cmd, arg), exp_rsps, rsp_exp && responds && (mode == 0), stray);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic stb_seen, ok;
    logic [31:0] arg52;
    logic [127:0] rnd;
    logic [135:0] r2;

    repeat (3) @(negedge clk);
    checkOutput("rstReady", 128'(o_ready), 128'(1));
    checkOutput("rstStb", 128'(o_rsps_stb), 128'(0));
    checkOutput("rstRsps", o_rsps, 128'(0));
    checkOutput("rstCrc", 128'(o_rsps_crc_good), 128'(0));
    checkOutput("rstTimeout", 128'(o_rsps_timeout), 128'(0));
    checkOutput("rstDir", 128'(o_sdio_cmd_dir), 128'(0));
    checkOutput("rstOut", 128'(o_sdio_cmd_out), 128'(1));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] CMD0, no response");
    applyStimulus(6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 2, 2'b11, '0,
                  48'h400000000095, '0, 1'b0, 1'b0);

    $display("[TB] CMD8 with valid R7");
    applyStimulus(6'd8, 32'h1AA, 1'b1, 1'b0, 1'b1, 5, 2'b11, {88'b0, 48'h08000001AA13},
                  48'h48000001AA87, {88'b0, 40'h08000001AA}, 1'b1, 1'b0);

    $display("[TB] CMD8 with corrupted CRC");
    applyStimulus(6'd8, 32'h1AA, 1'b1, 1'b0, 1'b1, 5, 2'b11, {88'b0, 48'h08000001AA15},
                  48'h48000001AA87, {88'b0, 40'h08000001AA}, 1'b0, 1'b0);

    $display("[TB] CMD52 timeout");
    arg52 = $urandom;
    applyStimulus(6'd52, arg52, 1'b1, 1'b0, 1'b0, 2, 2'b11, '0,
                  cmdFrame(6'd52, arg52), '0, 1'b0, 1'b0);

`ifdef SDIO_HOST_RSPS_136_EN
    $display("[TB] CMD2 with R2");
    rnd = {$urandom, $urandom, $urandom, $urandom};
    r2 = longResp(rnd[119:0], 0);
    applyStimulus(6'd2, 32'h0, 1'b1, 1'b1, 1'b1, 7, 2'b11, r2,
                  cmdFrame(6'd2, 32'h0), r2[127:0], 1'b1, 1'b0);
`endif

    $display("[TB] abort at bit 20");
    @(negedge clk);
    i_cmd = 6'd17; i_cmd_arg = $urandom; i_rsps_expected = 1'b1; i_long_rsps = 1'b0;
    i_cmd_stb = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      i_cmd_stb = 1'b0;
      if (c == 20) i_abort = 1'b1;
    end
    @(negedge clk);
    i_abort = 1'b0;
    checkOutput("abortDir", 128'(o_sdio_cmd_dir), 128'(0));
    checkOutput("abortOut", 128'(o_sdio_cmd_out), 128'(1));
    checkOutput("abortReady", 128'(o_ready), 128'(1));
    stb_seen = o_rsps_stb;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (o_rsps_stb) stb_seen = 1'b1;
    end
    checkOutput("abortNoStb", 128'(stb_seen), 128'(0));
    applyStimulus(6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 2, 2'b11, '0,
                  48'h400000000095, '0, 1'b0, 1'b0);

    $display("[TB] abort and command together");
    @(negedge clk);
    i_cmd = 6'd3; i_rsps_expected = 1'b0; i_cmd_stb = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_cmd_stb = 1'b0; i_abort = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (!o_ready || o_sdio_cmd_dir) ok = 1'b0;
      @(negedge clk);
    end
    checkOutput("abortWins", 128'(ok), 128'(1));

    $display("[TB] reset mid-frame");
    i_cmd = 6'd5; i_cmd_arg = $urandom; i_rsps_expected = 1'b0; i_cmd_stb = 1'b1;
    @(negedge clk);
    i_cmd_stb = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("preResetDir", 128'(o_sdio_cmd_dir), 128'(1));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("asyncResetDir", 128'(o_sdio_cmd_dir), 128'(0));
    checkOutput("asyncResetOut", 128'(o_sdio_cmd_out), 128'(1));
    checkOutput("asyncResetReady", 128'(o_ready), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] randomized transactions");
    for (int t = 0; t < 24; t++) randomTransaction();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
